aes_iter_core: RTL and testbench

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_iter_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_aes_iter_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// aes_iter_core -- iterative AES-128 encryption core.
//
// Accepts one 128-bit block with its key through a valid/ready handshake,
// runs UNROLL rounds per clock with on-the-fly key expansion, and presents
// the ciphertext through a second valid/ready handshake.
//
// Parameter:
//   UNROLL     rounds computed per clock (1, 2, 5 or 10); 10/UNROLL cycles per block
//
// Ports (all 128-bit buses use FIPS-197 byte order, bit 0 = MSB of byte 0):
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   IN_VALID   KEY/PT valid
//   IN_READY   core idle and able to accept a block
//   KEY        AES-128 cipher key, sampled only at acceptance
//   PT         plaintext block, sampled only at acceptance
//   OUT_VALID  CT holds a finished block
//   OUT_READY  consumer accepts CT
//   CT         ciphertext, holds its last value after hand-off
//
// Optional feature, macro AES_ITER_CORE_CBC_EN (undefined = plain ECB):
//   IV         initial chaining value
//   IV_LOAD    loads the chain register from IV while idle
//   The initial state becomes PT ^ chain ^ KEY and each result becomes the
//   next chain value (CBC encryption).
module aes_iter_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [0:127] KEY,
  input  logic [0:127] PT,
`ifdef AES_ITER_CORE_CBC_EN
  input  logic [0:127] IV,
  input  logic         IV_LOAD,
`endif
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [0:127] CT
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] STEP = 4'(UNROLL);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) and AES round primitives
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as inverse (x^254, which also maps 0 to 0) followed by
  // the affine transform, so no lookup table is inferred.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the state sits at [127-8i -: 8]; bytes are column-major
  // (byte = 4*column + row).
  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = sbox(s[127 - 8*i -: 8]);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      if (last) begin
        o[127 - 32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return o ^ rk;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e       fsm_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [127:0] ct_q;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q;
  logic         last_step;

  logic [127:0] key_w;
  logic [127:0] pt_w;
  logic [127:0] init_state;

  assign key_w = KEY;
  assign pt_w  = PT;

`ifdef AES_ITER_CORE_CBC_EN
  logic [127:0] chain_q;
  logic [127:0] chain_in;

  // An IV load on the accepting edge must already chain into that block.
  assign chain_in   = IV_LOAD ? IV : chain_q;
  assign init_state = pt_w ^ chain_in ^ key_w;
`else
  assign init_state = pt_w ^ key_w;
`endif

  assign last_step = (rnd_q + STEP) == 4'd10;

  // UNROLL rounds chained combinationally; rnd_q counts completed rounds.
  always_comb begin : round_chain
    logic [127:0] st;
    logic [127:0] rk;
    logic [7:0]   rc;
    st = state_q;
    rk = rkey_q;
    rc = rcon_q;
    for (int unsigned j = 0; j < UNROLL; j++) begin
      rk = key_next(rk, rc);
      st = aes_round(st, rk, ({28'd0, rnd_q} + j + 32'd1) == 32'd10);
      rc = xtime(rc);
    end
    state_d = st;
    rkey_d  = rk;
    rcon_d  = rc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ct_q        <= '0;
      state_q     <= '0;
      rkey_q      <= '0;
      rcon_q      <= '0;
      rnd_q       <= '0;
`ifdef AES_ITER_CORE_CBC_EN
      chain_q     <= '0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
`ifdef AES_ITER_CORE_CBC_EN
          if (IV_LOAD) chain_q <= IV;
`endif
          if (IN_VALID && in_ready_q) begin
            state_q    <= init_state;
            rkey_q     <= key_w;
            rcon_q     <= 8'h01;
            rnd_q      <= '0;
            in_ready_q <= 1'b0;
            fsm_q      <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          rkey_q  <= rkey_d;
          rcon_q  <= rcon_d;
          rnd_q   <= rnd_q + STEP;
          if (last_step) begin
            ct_q        <= state_d;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
`ifdef AES_ITER_CORE_CBC_EN
            chain_q     <= state_d;
`endif
          end
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          fsm_q       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign CT        = ct_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Testbench for aes_iter_core: one instance per legal UNROLL value, driven
// with shared directed vectors (FIPS-197 appendices B/C, SP 800-38A CBC).
module tb_aes_iter_core;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         OUT_READY;
  logic [0:127] KEY;
  logic [0:127] PT;
`ifdef AES_ITER_CORE_CBC_EN
  logic [0:127] IV;
  logic         IV_LOAD;
  logic [0:127] iv_next;
  logic         iv_load_next;
`endif

  logic         in_ready  [4];
  logic         out_valid [4];
  logic [0:127] ct        [4];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes_iter_core #(.UNROLL(U)) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (in_ready[g]),
      .KEY       (KEY),
      .PT        (PT),
`ifdef AES_ITER_CORE_CBC_EN
      .IV        (IV),
      .IV_LOAD   (IV_LOAD),
`endif
      .OUT_VALID (out_valid[g]),
      .OUT_READY (OUT_READY),
      .CT        (ct[g])
    );
  end

  function automatic int unroll_of(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 10;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check the idle state of every instance after a reset or hand-off.
  task automatic check_idle(input string name, input logic [0:127] exp_ct);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || ct[i] !== exp_ct) begin
        n_fail++;
        $display("FAIL %s U=%0d: in_ready=%b out_valid=%b ct=%h, want 1 0 %h",
                 name, unroll_of(i), in_ready[i], out_valid[i], ct[i], exp_ct);
      end
    end
  endtask

  // Accept one block, scramble KEY/PT afterwards, check per-instance latency
  // and result; optionally hand the result off.
  task automatic run_block(input string name, input logic [0:127] key,
                           input logic [0:127] pt, input logic [0:127] exp,
                           input bit release_out);
    KEY       = key;
    PT        = pt;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b0;
`ifdef AES_ITER_CORE_CBC_EN
    IV      = iv_next;
    IV_LOAD = iv_load_next;
`endif
    step();
    IN_VALID = 1'b0;
    KEY      = ~key;
    PT       = ~pt;
`ifdef AES_ITER_CORE_CBC_EN
    IV_LOAD = 1'b0;
    IV      = ~iv_next;
`endif
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy U=%0d: in_ready=%b want 0", name, unroll_of(i), in_ready[i]);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (out_valid[i] !== (k >= 10 / unroll_of(i))) begin
          n_fail++;
          $display("FAIL %s latency U=%0d cycle %0d: out_valid=%b want %b",
                   name, unroll_of(i), k, out_valid[i], (k >= 10 / unroll_of(i)));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ct[i] !== exp) begin
        n_fail++;
        $display("FAIL %s ct U=%0d: got %h want %h", name, unroll_of(i), ct[i], exp);
      end
    end
    if (release_out) begin
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
      check_idle({name, " handoff"}, exp);
    end
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    KEY       = '0;
    PT        = '0;
`ifdef AES_ITER_CORE_CBC_EN
    IV           = '0;
    IV_LOAD      = 1'b0;
    iv_next      = '0;
    iv_load_next = 1'b1;
`endif
    step();
    step();
    RST = 1'b0;
    check_idle("reset", '0);
  endtask

  task automatic test_vectors();
    run_block("fips_b", KEY_B, PT_B, CT_B, 1'b1);
    run_block("fips_c", KEY_C, PT_C, CT_C, 1'b1);
  endtask

  task automatic test_hold();
    run_block("hold", KEY_C, PT_C, CT_C, 1'b0);
    KEY      = KEY_B;
    PT       = PT_B;
    IN_VALID = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ct[i] !== CT_C || in_ready[i] !== 1'b0 || out_valid[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL hold U=%0d cycle %0d: ct=%h in_ready=%b out_valid=%b, want %h 0 1",
                   unroll_of(i), k, ct[i], in_ready[i], out_valid[i], CT_C);
        end
      end
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check_idle("hold release", CT_C);
    repeat (12) step();
    check_idle("hold no queue", CT_C);
  endtask

  task automatic test_reset_mid_run();
    KEY      = KEY_B;
    PT       = PT_B;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    repeat (4) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_idle("reset mid run", '0);
    // Reset wins over a simultaneous accept.
    RST      = 1'b1;
    IN_VALID = 1'b1;
    step();
    RST      = 1'b0;
    IN_VALID = 1'b0;
    check_idle("reset priority", '0);
    repeat (10) step();
    check_idle("reset priority idle", '0);
    run_block("after reset", KEY_B, PT_B, CT_B, 1'b1);
  endtask

`ifdef AES_ITER_CORE_CBC_EN
  task automatic test_cbc();
    iv_next      = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load_next = 1'b1;
    run_block("cbc1", KEY_B, 128'h6bc1bee22e409f96e93d7e117393172a,
              128'h7649abac8119b246cee98e9b12e9197d, 1'b1);
    iv_load_next = 1'b0;
    run_block("cbc2", KEY_B, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
              128'h5086cb9b507219ee95db113a917678b2, 1'b1);
    iv_next      = '0;
    iv_load_next = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid_run();
`ifdef AES_ITER_CORE_CBC_EN
    test_cbc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
